// File: rtl/approx_mult_pkg.sv
// Shared definitions for the leading-one-truncation approximate multiplier engine:
// default geometry, FSM state encoding and width helpers.
package approx_mult_pkg;

    localparam int W_DEF         = 8;
    localparam int K_DEF         = 4;
    localparam int MAX_PAIRS_DEF = 16;
    localparam int S_DEF         = W_DEF - K_DEF;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WAIT_REL = 4'd1,
        ST_READ     = 4'd2,
        ST_LOAD     = 4'd3,
        ST_NORM     = 4'd4,
        ST_MULT     = 4'd5,
        ST_DENORM   = 4'd6,
        ST_WRITE    = 4'd7,
        ST_DONE     = 4'd8
    } state_e;

    // Maximum normalise shift per operand.
    function automatic int norm_shift(input int w, input int k);
        return w - k;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a per-operand shift counter that counts 0..s.
    function automatic int cnt_width(input int s);
        return (s > 0) ? $clog2(s + 1) : 1;
    endfunction

    // Width of the denormalise amount D, which ranges 0..2s.
    function automatic int denorm_width(input int s);
        return (s > 0) ? $clog2(2 * s + 1) : 1;
    endfunction

endpackage

// File: rtl/lo_norm_shifter.sv
// Leading-one normaliser for one operand: shifts left one bit per enabled cycle
// until the msb is set or the shift count reaches S.
module lo_norm_shifter
    import approx_mult_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int S = S_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic [W-1:0]              data_i,
    input  logic                      shift_i,
    output logic [W-1:0]              data_o,
    output logic                      msb_o,
    output logic [cnt_width(S)-1:0]   cnt_o,
    output logic                      need_shift_o
);

    localparam int CW = cnt_width(S);

    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign data_o       = data_q;
    assign msb_o        = data_q[W-1];
    assign cnt_o        = cnt_q;
    assign need_shift_o = !data_q[W-1] && (32'(cnt_q) < S);

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = data_i;
            cnt_d  = '0;
        end else if (shift_i && need_shift_o) begin
            data_d = data_q << 1;
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/approx_mult_engine.sv
// Approximate multiplier engine: walks num_pairs operand pairs from an operand RAM,
// normalises, multiplies the top K bits, denormalises and writes 2W-bit products.
module approx_mult_engine
    import approx_mult_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int K         = K_DEF,
    parameter int MAX_PAIRS = MAX_PAIRS_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [addr_width(MAX_PAIRS):0]  num_pairs_i,
    input  logic                            exact_mode_i,
    output logic                            rd_en_o,
    output logic [addr_width(MAX_PAIRS)-1:0] rd_addr_o,
    input  logic [2*W-1:0]                  rd_data_i,
    output logic                            wr_en_o,
    output logic [addr_width(MAX_PAIRS)-1:0] wr_addr_o,
    output logic [2*W-1:0]                  wr_data_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int S  = norm_shift(W, K);
    localparam int AW = addr_width(MAX_PAIRS);
    localparam int CW = cnt_width(S);
    localparam int DW = denorm_width(S);

    state_e         state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [AW:0]    np_q, np_d;
    logic           exact_q, exact_d;
    logic [2*W-1:0] res_q, res_d;
    logic [DW-1:0]  d_q, d_d;
    logic [DW-1:0]  dcnt_q, dcnt_d;

    logic           op_load;
    logic           op_shift;
    logic [W-1:0]   op_data [2];
    logic           op_msb  [2];
    logic [CW-1:0]  op_cnt  [2];
    logic           op_need [2];

    // Operand 0 is A (upper half of the RAM word), operand 1 is B.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_norm
            lo_norm_shifter #(
                .W (W),
                .S (S)
            ) u_norm (
                .clk          (clk),
                .rst          (rst),
                .load_i       (op_load),
                .data_i       (rd_data_i[(2-gi)*W-1 -: W]),
                .shift_i      (op_shift),
                .data_o       (op_data[gi]),
                .msb_o        (op_msb[gi]),
                .cnt_o        (op_cnt[gi]),
                .need_shift_o (op_need[gi])
            );
        end
    endgenerate

    logic           norm_done;
    logic           pair_zero;
    logic           last_pair;
    logic [AW:0]    np_clamped;
    logic [K-1:0]   top_a, top_b;
    logic [2*K-1:0] prod_trunc;
    logic [2*W-1:0] prod_exact;

    // An operand is settled once it is normalised or its shift budget is spent.
    assign norm_done  = (op_msb[0] || !op_need[0]) && (op_msb[1] || !op_need[1]);
    assign pair_zero  = (rd_data_i[2*W-1:W] == '0) || (rd_data_i[W-1:0] == '0);
    assign last_pair  = ({1'b0, idx_q} == (np_q - (AW+1)'(1)));
    assign np_clamped = (num_pairs_i > (AW+1)'(MAX_PAIRS)) ? (AW+1)'(MAX_PAIRS) : num_pairs_i;

    assign top_a      = op_data[0][W-1 -: K];
    assign top_b      = op_data[1][W-1 -: K];
    assign prod_trunc = (2*K)'(top_a) * (2*K)'(top_b);
    assign prod_exact = {{W{1'b0}}, op_data[0]} * {{W{1'b0}}, op_data[1]};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        np_d     = np_q;
        exact_d  = exact_q;
        res_d    = res_q;
        d_d      = d_q;
        dcnt_d   = dcnt_q;
        op_load  = 1'b0;
        op_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!start_i) begin
                    np_d    = np_clamped;
                    exact_d = exact_mode_i;
                    idx_d   = '0;
                    state_d = (num_pairs_i == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                op_load = 1'b1;
                if (pair_zero) begin
                    res_d   = '0;
                    state_d = ST_WRITE;
                end else if (exact_q) begin
                    state_d = ST_MULT;
                end else begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                op_shift = 1'b1;
                if (norm_done) state_d = ST_MULT;
            end
            ST_MULT: begin
                if (exact_q) begin
                    res_d   = prod_exact;
                    state_d = ST_WRITE;
                end else begin
                    res_d   = (2*W)'(prod_trunc);
                    d_d     = DW'(2 * S) - DW'(op_cnt[0]) - DW'(op_cnt[1]);
                    dcnt_d  = '0;
                    state_d = ST_DENORM;
                end
            end
            ST_DENORM: begin
                if (dcnt_q == d_q) begin
                    state_d = ST_WRITE;
                end else begin
                    res_d  = res_q << 1;
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            ST_WRITE: begin
                if (last_pair) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            np_q    <= '0;
            exact_q <= 1'b0;
            res_q   <= '0;
            d_q     <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            np_q    <= np_d;
            exact_q <= exact_d;
            res_q   <= res_d;
            d_q     <= d_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Address and data buses are held at zero outside their strobes.
    assign rd_en_o   = (state_q == ST_READ);
    assign rd_addr_o = rd_en_o ? idx_q : '0;
    assign wr_en_o   = (state_q == ST_WRITE);
    assign wr_addr_o = wr_en_o ? idx_q : '0;
    assign wr_data_o = wr_en_o ? res_q : '0;
    assign busy_o    = (state_q == ST_READ)   || (state_q == ST_LOAD) ||
                       (state_q == ST_NORM)   || (state_q == ST_MULT) ||
                       (state_q == ST_DENORM) || (state_q == ST_WRITE);
    assign done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_approx_mult_engine.sv
// Self-checking bench for approx_mult_engine: directed cases plus random jobs
// compared against an arithmetic model of leading-one truncation.
module tb_approx_mult_engine;

    localparam int W         = 8;
    localparam int K         = 4;
    localparam int MAX_PAIRS = 16;
    localparam int AW        = 4;
    localparam int S         = W - K;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            exact_mode = 1'b0;
    logic [AW:0]     num_pairs = '0;
    logic            rd_en, wr_en, busy, done;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [2*W-1:0]  rd_data;
    logic [2*W-1:0]  wr_data;
    logic [2*W-1:0]  op_mem [MAX_PAIRS];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    approx_mult_engine #(
        .W         (W),
        .K         (K),
        .MAX_PAIRS (MAX_PAIRS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .num_pairs_i  (num_pairs),
        .exact_mode_i (exact_mode),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    // Operand RAM with one-cycle registered read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= op_mem[rd_addr];
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lead_zeros(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return W - 1 - i;
        end
        return W;
    endfunction

    // Expected product and cycles from READ to WRITE inclusive.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit ex,
                                  output longint p, output int cycles);
        int sa, sb, d, ta, tb;
        if (a == 0 || b == 0) begin
            p = 0;
            cycles = 3;
        end else if (ex) begin
            p = longint'(a) * longint'(b);
            cycles = 4;
        end else begin
            sa = lead_zeros(a); if (sa > S) sa = S;
            sb = lead_zeros(b); if (sb > S) sb = S;
            ta = ((int'(a) << sa) & ((1 << W) - 1)) >> (W - K);
            tb = ((int'(b) << sb) & ((1 << W) - 1)) >> (W - K);
            d  = 2 * S - sa - sb;
            p  = longint'(ta * tb) << d;
            cycles = 6 + ((sa > sb) ? sa : sb) + d;
        end
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom % 5)
            0:       return '0;
            1:       return W'($urandom_range(1, 15));
            2:       return W'($urandom_range(128, 255));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic fill_random();
        for (int i = 0; i < MAX_PAIRS; i++) op_mem[i] = {rand_op(), rand_op()};
    endtask

    task automatic run_job(input int np, input bit ex, input int hold, input int pulse_at);
        int     rd_cyc, last_wr, n_wr, exp_cyc;
        longint exp_p;
        bit     got_done;
        @(negedge clk);
        num_pairs  = (AW+1)'(np);
        exact_mode = ex;
        start      = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("busy_during_hold", busy, 0);
        end
        start    = 1'b0;
        n_wr     = 0;
        got_done = 0;
        rd_cyc   = 0;
        last_wr  = 0;
        for (int t = 0; t < 400 && !got_done; t++) begin
            @(negedge clk);
            if (t == 0) chk("busy_on_release", busy, (np != 0));
            if (t == pulse_at) begin
                start      = 1'b1;
                num_pairs  = (AW+1)'($urandom_range(0, MAX_PAIRS));
                exact_mode = ~ex;
            end else if (t == pulse_at + 1) begin
                start = 1'b0;
            end
            if (rd_en) begin
                rd_cyc = cyc;
                chk("rd_addr", rd_addr, n_wr);
            end
            if (wr_en) begin
                if (n_wr < MAX_PAIRS) begin
                    model(op_mem[n_wr][2*W-1:W], op_mem[n_wr][W-1:0], ex, exp_p, exp_cyc);
                    $display("[TB] pair %0d A=%02h B=%02h exact=%0b wr_data=%0d expected=%0d",
                             n_wr, op_mem[n_wr][2*W-1:W], op_mem[n_wr][W-1:0], ex, wr_data, exp_p);
                    chk("wr_addr", wr_addr, n_wr);
                    chk("wr_data", wr_data, exp_p);
                    chk("rd_to_wr_latency", cyc - rd_cyc, exp_cyc - 1);
                end else begin
                    chk("extra_write", n_wr, np);
                end
                last_wr = cyc;
                n_wr++;
            end
            if (done) begin
                got_done = 1;
                chk("write_count", n_wr, np);
                if (np != 0) chk("done_after_last_wr", cyc - last_wr, 1);
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_single_pulse", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        int n_rd, n_wr_after;
        bit seen;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_data", wr_data, 0);
        rst = 1'b0;

        // Leading-zero capping on B and one-step denormalise.
        op_mem[0] = {8'h16, 8'h05};
        run_job(1, 1'b0, 1, -1);

        // Fully normalised operands, then the same pair in exact mode.
        op_mem[0] = {8'hFF, 8'hFF};
        run_job(1, 1'b0, 1, -1);
        run_job(1, 1'b1, 1, -1);

        // Zero fast path and a maximal denormalise.
        op_mem[0] = {8'h00, 8'h07};
        op_mem[1] = {8'h03, 8'h00};
        op_mem[2] = {8'h80, 8'h80};
        run_job(3, 1'b0, 1, -1);

        // Long start hold, then a start pulse and input changes mid-job.
        fill_random();
        run_job(8, 1'b0, 5, 3);

        // Reset during DENORM of pair 1 of a 4-pair job.
        fill_random();
        op_mem[1] = {8'hFF, 8'hFF};
        @(negedge clk);
        num_pairs  = 5'd4;
        exact_mode = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_rd  = 0;
        seen  = 0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (rd_en) n_rd++;
            if (n_rd == 2) seen = 1;
        end
        chk("reach_pair1", seen, 1);
        repeat (4) @(negedge clk);
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wr_data", wr_data, 0);
        chk("abort_wr_addr", wr_addr, 0);
        rst = 1'b0;
        n_wr_after = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (wr_en || busy || done) n_wr_after++;
        end
        chk("quiet_after_abort", n_wr_after, 0);
        run_job(4, 1'b0, 1, -1);

        // Full depth and empty job.
        fill_random();
        run_job(MAX_PAIRS, 1'b0, 1, -1);
        run_job(MAX_PAIRS, 1'b1, 2, -1);
        run_job(0, 1'b0, 1, -1);

        // Random jobs.
        for (int j = 0; j < 8; j++) begin
            fill_random();
            run_job($urandom_range(1, MAX_PAIRS), 1'($urandom % 2), $urandom_range(1, 3), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
